// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types, parameter legality check and flag reset constants for sync_fifo_v2
package sync_fifo_pkg;
  localparam int DEF_DEPTH = 8;
  typedef logic [$clog2(DEF_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEF_DEPTH):0] cnt_t;
  localparam logic OVF_RST = 1'b0;
  localparam logic UDF_RST = 1'b0;
  function automatic bit params_ok(input int depth, input int af, input int ae);
    return depth >= 2 && (depth & (depth - 1)) == 0 && af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register file, one write port, asynchronous read, no reset
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with thresholds and sticky errors; define SYNC_FIFO_FWFT_EN for first-word-fall-through
module sync_fifo_v2 import sync_fifo_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     write,
  input  logic                     read,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_v2: illegal DEPTH/AF_LEVEL/AE_LEVEL");
  end
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_acc, wr_acc;
  assign empty        = cnt == '0;
  assign full         = cnt == CW'(DEPTH);
  assign almost_full  = cnt >= CW'(AF_LEVEL);
  assign almost_empty = cnt <= CW'(AE_LEVEL);
  assign rd_acc       = read && !empty;
  // a read at full frees a slot, so a simultaneous write is still accepted
  assign wr_acc       = write && (!full || rd_acc);
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc && !clear),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= OVF_RST;
      underflow <= UDF_RST;
    end else begin
      wr_ptr    <= wr_ptr + PW'(wr_acc);
      rd_ptr    <= rd_ptr + PW'(rd_acc);
      cnt       <= cnt + CW'(wr_acc) - CW'(rd_acc);
      overflow  <= overflow | (write && !wr_acc);
      underflow <= underflow | (read && !rd_acc);
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : rd_data;
`else
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || clear) data_out <= '0;
    else if (rd_acc) data_out <= rd_data;
`endif
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: directed self-checking bench for sync_fifo_v2 (standard mode, or FWFT with SYNC_FIFO_FWFT_EN)
module tb_sync_fifo_v2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  cnt;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb [$];
  logic [31:0] d;

  sync_fifo_v2 #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .write        (write),
    .read         (read),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .cnt          (cnt),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one cycle of traffic; data is checked before the edge in FWFT, after it in standard mode
  task automatic op(input logic w, input logic r, input logic [31:0] din,
                    input logic chk_d, input logic [31:0] exp, input string tag);
    write = w;
    read = r;
    data_in = din;
`ifdef SYNC_FIFO_FWFT_EN
    if (chk_d) chk(tag, data_out, exp);
`endif
    tick();
    write = 1'b0;
    read = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    if (chk_d) chk(tag, data_out, exp);
`endif
  endtask

  initial begin
    #3;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 1'b0, 32'h11 * i, 1'b0, 0, "");
      chk("fill_cnt", 32'(cnt), i);
      chk("fill_af", 32'(almost_full), (i >= 7) ? 1 : 0);
      chk("fill_ae", 32'(almost_empty), (i <= 1) ? 1 : 0);
    end
    chk("fill_full", 32'(full), 1);
    op(1'b1, 1'b0, 32'h99, 1'b0, 0, "");
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_cnt", 32'(cnt), 8);

    for (int i = 1; i <= 8; i++) begin
      op(1'b0, 1'b1, 0, 1'b1, 32'h11 * i, "drain_data");
      chk("drain_cnt", 32'(cnt), 8 - i);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("pre_udf", 32'(underflow), 0);
    op(1'b0, 1'b1, 0, 1'b0, 0, "");
    chk("udf_set", 32'(underflow), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("udf_dout", data_out, 0);
`else
    chk("udf_dout", data_out, 32'h88);
`endif

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);
    op(1'b1, 1'b1, 32'hA1, 1'b0, 0, "");
    chk("rw_empty_cnt", 32'(cnt), 1);
    chk("rw_empty_udf", 32'(underflow), 1);
    chk("rw_empty_nempty", 32'(empty), 0);
    for (int i = 2; i <= 8; i++) op(1'b1, 1'b0, 32'hA0 + i, 1'b0, 0, "");
    chk("refill_full", 32'(full), 1);
    op(1'b1, 1'b1, 32'hB0, 1'b1, 32'hA1, "rw_full_data");
    chk("rw_full_cnt", 32'(cnt), 8);
    chk("rw_full_ovf", 32'(overflow), 0);
    for (int i = 2; i <= 8; i++) op(1'b0, 1'b1, 0, 1'b1, 32'hA0 + i, "rw_full_drain");
    op(1'b0, 1'b1, 0, 1'b1, 32'hB0, "rw_full_last");
    chk("rw_full_empty", 32'(empty), 1);

    for (int i = 0; i < 3; i++) begin
      d = 32'h9E3779B9 * (i + 1);
      sb.push_back(d);
      op(1'b1, 1'b0, d, 1'b0, 0, "");
    end
    for (int i = 3; i < 23; i++) begin
      d = 32'h9E3779B9 * (i + 1);
      op(1'b1, 1'b1, d, 1'b1, sb.pop_front(), "wrap_data");
      sb.push_back(d);
    end
    chk("wrap_cnt", 32'(cnt), 3);

    op(1'b1, 1'b0, 32'h55, 1'b0, 0, "");
    op(1'b1, 1'b0, 32'h66, 1'b0, 0, "");
    chk("pre_clr_cnt", 32'(cnt), 5);
    clear = 1'b1;
    write = 1'b1;
    data_in = 32'h77;
    tick();
    clear = 1'b0;
    write = 1'b0;
    chk("clr_cnt", 32'(cnt), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_ae", 32'(almost_empty), 1);
    chk("clr_udf2", 32'(underflow), 0);
    chk("clr_dout", data_out, 0);

    op(1'b1, 1'b0, 32'hC1, 1'b0, 0, "");
    op(1'b1, 1'b0, 32'hC2, 1'b0, 0, "");
    op(1'b1, 1'b1, 32'hC3, 1'b1, 32'hC1, "burst_data");
    write = 1'b1;
    data_in = 32'hC4;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_dout", data_out, 0);
    write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    op(1'b1, 1'b0, 32'hD1, 1'b0, 0, "");
`ifdef SYNC_FIFO_FWFT_EN
    chk("post_rst_dout", data_out, 32'hD1);
`else
    chk("post_rst_dout", data_out, 0);
`endif
    op(1'b0, 1'b1, 0, 1'b1, 32'hD1, "post_rst_read");
    chk("post_rst_empty", 32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_v2.md
# sync_fifo_v2

Parametrised single-clock FIFO, the next-generation buffer for datapath staging between producer and consumer blocks in one clock domain. It adds concurrent read+write in every occupancy state, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. A compile-time first-word-fall-through (FWFT) mode is also available. Storage is a separate non-reset register-file sub-module; the controller holds pointers, count and flags.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full threshold; legal range 1..DEPTH
- AE_LEVEL, 1, almost_empty threshold; legal range 0..DEPTH-1
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush, active high
- write  input  1  write request
- read  input  1  read request
- data_in  input  WIDTH  write data
- data_out  output  WIDTH  read data
- full  output  1  cnt == DEPTH
- empty  output  1  cnt == 0
- almost_full  output  1  cnt >= AF_LEVEL
- almost_empty  output  1  cnt <= AE_LEVEL
- cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write was rejected
- underflow  output  1  sticky: read was rejected

## Operation
- Reset (reset_n low, asynchronous) values: pointers=0, cnt=0, data_out=0, overflow=0, underflow=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0).
- Memory contents are not reset.
- clear: same effect as reset, but synchronous; overrides read and write in the same cycle.
- rd_acc = read && !empty.
- wr_acc = write && (!full || rd_acc). When full, a simultaneous read+write accepts both.
- cnt_next = cnt + wr_acc − rd_acc. Simultaneous accepted read+write leaves cnt unchanged.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Each advances only on its own acc signal.
- Write at full with no read: data dropped, overflow set.
- Read at empty: ignored, underflow set. A write in the same cycle is still accepted.
- overflow and underflow hold until reset or clear.
- Flags are combinational from the registered cnt.

## Timing
- Standard mode: data_out is registered. It loads mem[rd_ptr] on the edge where rd_acc=1 and is valid the following cycle (1-cycle read latency). It holds its value otherwise.
- Write: data is captured at the edge where wr_acc=1. The word is readable from the next cycle, after empty deasserts.
- Full with read+write: the read returns the old head and the write lands in the freed slot. No corruption.
- Flags and cnt reflect an operation in the cycle after its accepting edge.
- reset_n asserted mid-operation: all state clears immediately; in-flight accepted data is lost.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - read pops the word currently presented; the next word appears after that edge.
  - A word written into an empty FIFO appears on data_out one cycle after its write edge.
  - No registered data_out.
- Macro undefined: standard registered mode as described in Operation and Timing.
- Flags, cnt and error behaviour are identical in both modes.

## Structure
- Package sync_fifo_pkg:
  - cnt_t and ptr_t typedef helpers, derived from DEPTH via $clog2.
  - Localparam-compatible function that checks DEPTH is a power of two and the thresholds are in range.
  - Reset constants for the flags.
- Sub-module fifo_mem: WIDTH×DEPTH register file, one write port and one asynchronous read port, no reset. Instantiated once.
- Top module: pointers, cnt, acceptance logic, flags, error flags and the data_out register (standard mode).

## Test plan
- Reset then fill: write 0x11..0x88 on 8 consecutive cycles.
  - full=1 and cnt=8 after the 8th edge.
  - almost_full first rises at cnt=7.
  - A 9th write sets overflow=1 and cnt stays 8.
- Drain: read 8 times.
  - Standard mode: data_out = 0x11..0x88 in order, each one cycle after its read.
  - Then empty=1.
  - A 9th read sets underflow=1 and data_out holds 0x88.
- Simultaneous read+write:
  - At full: cnt stays 8, the read returns the oldest word, and the new word is returned last.
  - At empty: the write is accepted, cnt=1 and underflow=1.
- Wrap-around: 20 interleaved write/read pairs with pseudo-random data. Scoreboard shows no mismatch across pointer wrap.
- clear with cnt=5 and write=1 in the same cycle: next cycle cnt=0, empty=1, flags cleared, data_out=0.
- reset_n pulsed low mid-burst (asynchronous, between clock edges): outputs go to reset values immediately. With SYNC_FIFO_FWFT_EN, data_out=0 while empty and shows the first written word one cycle after its write.
